// File: rtl/lsu_unit.sv
`default_nettype none
// ============================================================================
// Module      : lsu_unit
// Description : RV32I load/store unit. Accepts an effective address, funct3,
//               store data and rd tag from execute, runs one req/ack access on
//               a word-addressed data bus with byte enables, and returns
//               extended load data or a fault code to writeback.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     request handshake from execute
//   in_opcode/in_funct3   load (0000011) / store (0100011), access size/sign
//   in_addr/in_wdata      effective address, store data (rs2)
//   in_rd                 destination register tag
//   mem_req/mem_we        bus request (held until ack), write strobe
//   mem_addr/mem_be       word address, byte enables
//   mem_wdata             lane-aligned store data
//   mem_ack/mem_rdata     bus completion, read word (same cycle as ack)
//   out_valid/out_we      one-cycle completion pulse, register write enable
//   out_rd/out_data       completed tag, extended load data
//   out_fault             00 ok, 01 misaligned/illegal, 10 bus timeout
// ============================================================================
module lsu_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic        out_we,
  output logic [4:0]  out_rd,
  output logic [31:0] out_data,
  output logic [1:0]  out_fault
);

  localparam logic [6:0]  C_OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  C_OP_STORE = 7'b0100011;
  localparam logic [15:0] C_TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  rd_q, rd_d;
  logic        is_load_q, is_load_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [29:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  fault_q, fault_d;
  logic        owe_q, owe_d;

  logic        w_is_load, w_is_store, w_accept, w_legal, w_misaligned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_shifted, w_ext;
  logic [15:0] w_half;

  assign w_is_load  = (in_opcode == C_OP_LOAD);
  assign w_is_store = (in_opcode == C_OP_STORE);
  assign w_accept   = in_valid && (state_q == S_IDLE) && (w_is_load || w_is_store);

  // Request decode: legality, alignment, byte enables, lane replication.
  always_comb begin
    w_legal = 1'b0;
    case (in_funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = w_is_load;  // unsigned forms exist for loads only
      default:                w_legal = 1'b0;
    endcase
    w_misaligned = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                   ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
    case (in_funct3[1:0])
      2'b00:   begin w_be = 4'b0001 << in_addr[1:0]; w_wdata = {4{in_wdata[7:0]}};  end
      2'b01:   begin w_be = 4'b0011 << in_addr[1:0]; w_wdata = {2{in_wdata[15:0]}}; end
      default: begin w_be = 4'b1111;                 w_wdata = in_wdata;            end
    endcase
  end

  // Load extraction from the read word using the latched offset and funct3.
  assign w_shifted = mem_rdata >> {off_q, 3'b000};
  assign w_half    = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    case (f3_q)
      3'b000:  w_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b100:  w_ext = {24'd0, w_shifted[7:0]};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext = {16'd0, w_half};
      default: w_ext = mem_rdata;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    f3_d      = f3_q;
    off_d     = off_q;
    rd_d      = rd_q;
    is_load_d = is_load_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    fault_d   = fault_q;
    owe_d     = owe_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          f3_d      = in_funct3;
          off_d     = in_addr[1:0];
          rd_d      = in_rd;
          is_load_d = w_is_load;
          if (!w_legal || w_misaligned) begin
            state_d = S_DONE;
            fault_d = 2'b01;
            data_d  = 32'd0;
            owe_d   = 1'b0;
          end else begin
            state_d = S_BUS;
            req_d   = 1'b1;
            we_d    = w_is_store;
            addr_d  = in_addr[31:2];
            be_d    = w_be;
            wdata_d = w_wdata;
            cnt_d   = 16'd0;
          end
        end
      end
      S_BUS: begin
        // Ack is checked first so an ack on the final cycle beats the timeout.
        if (mem_ack) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          fault_d = 2'b00;
          data_d  = is_load_q ? w_ext : 32'd0;
          owe_d   = is_load_q && (rd_q != 5'd0);
        end else if (cnt_q == C_TMO_LAST) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          fault_d = 2'b10;
          data_d  = 32'd0;
          owe_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      f3_q      <= 3'd0;
      off_q     <= 2'd0;
      rd_q      <= 5'd0;
      is_load_q <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 30'd0;
      be_q      <= 4'd0;
      wdata_q   <= 32'd0;
      cnt_q     <= 16'd0;
      data_q    <= 32'd0;
      fault_q   <= 2'b00;
      owe_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
      rd_q      <= rd_d;
      is_load_q <= is_load_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      fault_q   <= fault_d;
      owe_q     <= owe_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign out_valid = (state_q == S_DONE);
  assign out_we    = out_valid & owe_q;
  assign out_rd    = rd_q;
  assign out_data  = out_valid ? data_q : 32'd0;
  assign out_fault = out_valid ? fault_q : 2'b00;

endmodule
`default_nettype wire

// File: doc/lsu_unit.md
Name: lsu_unit

Overview:
- Load/store unit directly downstream of the ALU in the RV32I execute path.
- Takes the effective address the ALU computes for opcodes 0000011 (load) and 0100011 (store), plus funct3 and the rs2 store data.
- Runs a req/ack transaction on a 32-bit word-addressed data-memory bus with byte enables.
- Returns sign/zero-extended load data, or a fault, to writeback.

Parameters:
TIMEOUT, 255, max cycles mem_req is held without mem_ack before the access aborts with a fault (1..65535)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request from execute
in_ready  out  1  high when unit can accept (state IDLE)
in_opcode  in  7  0000011 load, 0100011 store; any other value ignored
in_funct3  in  3  access size/sign
in_addr  in  32  effective address (ALU result)
in_wdata  in  32  store data (rs2)
in_rd  in  5  destination register tag
mem_req  out  1  bus request, held until mem_ack
mem_we  out  1  1 = write
mem_addr  out  30  word address = in_addr[31:2]
mem_be  out  4  byte enables
mem_wdata  out  32  lane-aligned store data
mem_ack  in  1  bus completion; mem_rdata valid same cycle for reads
mem_rdata  in  32  read word
out_valid  out  1  one-cycle completion pulse, no backpressure
out_we  out  1  1 = write out_data to out_rd (successful load only)
out_rd  out  5  tag of completed access
out_data  out  32  extended load data; 0 for stores and faults
out_fault  out  2  00 ok, 01 misaligned/illegal funct3, 10 bus timeout

Behaviour:
- Reset (async, rst_n=0) returns the unit to IDLE. Reset values:
  - in_ready=1
  - mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0
  - out_valid=0, out_we=0, out_rd=0, out_data=0, out_fault=00
  - timeout counter=0
  - Reset mid-transaction drops mem_req immediately; no completion is reported.
- States: IDLE, BUS, DONE.
- IDLE:
  - Accept when in_valid && in_ready && opcode is load/store; otherwise stay in IDLE.
  - On accept, latch funct3, addr[1:0], rd, and load/store.
  - Legality rules:
    - Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
    - Legal store funct3: 000 SB, 001 SH, 010 SW.
    - Misaligned: halfword with addr[0]=1; word with addr[1:0]!=00.
  - Illegal or misaligned: go to DONE with fault 01 and no bus activity.
  - Legal: drive mem_req=1, mem_we, mem_addr, mem_be and mem_wdata registered at the next edge, go to BUS, clear counter.
- Byte enables:
  - SB/LB/LBU: 0001<<addr[1:0].
  - SH/LH/LHU: 0011<<addr[1:0].
  - SW/LW: 1111.
- Store data: SB replicates byte[7:0] on all 4 lanes; SH replicates half[15:0] on both halves; SW passes through.
- BUS:
  - Bus outputs are stable while mem_req=1.
  - mem_ack=1 (sampled, including the first BUS cycle): drop mem_req, capture the extracted load data, go to DONE with fault 00.
  - No ack: counter increments each cycle. When counter==TIMEOUT-1 without ack, drop mem_req and go to DONE with fault 10. Ack on that same cycle wins over the timeout.
  - mem_ack outside BUS is ignored.
- Load extraction from mem_rdata:
  - Byte selected by addr[1:0]; halfword selected by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- DONE: out_valid=1 for exactly one cycle with the registered results, then IDLE.
  - out_we=1 only for a successful load with rd!=0.
  - in_ready=0 in BUS and DONE, so a new request is accepted no earlier than the cycle after out_valid.
- Latency:
  - Fault path: accept edge t, out_valid at t+1.
  - Bus path: ack sampled at edge t+k (k>=1), out_valid at t+k+1.
  - Minimum bus-path accept-to-accept is 3 cycles.

Test Plan:
- LB addr 0x1003, mem_rdata 0x80FF_1234, ack on first BUS cycle -> mem_addr=0x400, mem_be=1000, mem_we=0; out_data=0xFFFFFF80, out_we=1, fault 00, out_valid 2 cycles after accept.
- SH addr 0x2002, wdata 0xDEAD_BEEF -> mem_be=1100, mem_wdata=0xBEEF_BEEF, mem_we=1; out_we=0, out_data=0, fault 00.
- LW addr 0x2001 -> no mem_req; out_valid 1 cycle after accept with fault 01, out_we=0. Repeat with load funct3=011 -> same.
- LHU addr 0x10 with ack held low, TIMEOUT=4 -> mem_req high exactly 4 cycles then low; out_valid with fault 10. Repeat with ack on the 4th cycle -> fault 00 and load data returned.
- Back-to-back: in_valid held high with 2 loads, ack immediate -> second accept only after first out_valid; rd tags returned in order; in_ready low in BUS/DONE.
- rst_n pulsed low while mem_req=1 -> mem_req, out_valid=0 asynchronously; in_ready=1 after release; a late mem_ack is ignored.
